// File: rtl/bitwise_gates_pkg.sv
// Shared definitions for the bit-serial bitwise gate block.
// Optional feature macro: BITWISE_GATES_XOR_EN (adds xor/xnor results).
package bitwise_gates_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned NBITS_MAX = 32;

endpackage

// File: rtl/bitwise_gates_bit.sv
// Single 1-bit gate cell shared by every bit position of the serial block.
// Optional feature macro: BITWISE_GATES_XOR_EN (adds y_xor/y_xnor).
module bitwise_gates_bit (
    input  logic a,
    input  logic b,
`ifdef BITWISE_GATES_XOR_EN
    output logic y_xor,
    output logic y_xnor,
`endif
    output logic y_and,
    output logic y_nand,
    output logic y_or,
    output logic y_nor
);

    assign y_and  = a & b;
    assign y_nand = ~(a & b);
    assign y_or   = a | b;
    assign y_nor  = ~(a | b);
`ifdef BITWISE_GATES_XOR_EN
    assign y_xor  = a ^ b;
    assign y_xnor = ~(a ^ b);
`endif

endmodule

// File: rtl/bitwise_gates_serial.sv
// Bit-serial AND/NAND/OR/NOR of two nbits operands, LSB first, through one
// gate cell, with valid/ready handshakes on both sides.
// Optional feature macro: BITWISE_GATES_XOR_EN (adds out_xor/out_xnor).
module bitwise_gates_serial
    import bitwise_gates_pkg::*;
#(
    parameter int unsigned nbits = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [nbits-1:0] in0,
    input  logic [nbits-1:0] in1,
    output logic             out_val,
    input  logic             out_rdy,
`ifdef BITWISE_GATES_XOR_EN
    output logic [nbits-1:0] out_xor,
    output logic [nbits-1:0] out_xnor,
`endif
    output logic [nbits-1:0] out_and,
    output logic [nbits-1:0] out_nand,
    output logic [nbits-1:0] out_or,
    output logic [nbits-1:0] out_nor
);

    localparam int unsigned CW = $clog2(nbits);
    localparam logic [CW-1:0] CNT_LAST = CW'(nbits - 1);

    if (nbits < 2 || nbits > NBITS_MAX) begin : g_nbits_range
        $error("bitwise_gates_serial: nbits out of range");
    end

    state_e          state;
    logic [CW-1:0]   cnt;
    logic [nbits-1:0] opa;
    logic [nbits-1:0] opb;
    logic            g_and;
    logic            g_nand;
    logic            g_or;
    logic            g_nor;
`ifdef BITWISE_GATES_XOR_EN
    logic            g_xor;
    logic            g_xnor;
`endif

    bitwise_gates_bit u_bit (
        .a      (opa[0]),
        .b      (opb[0]),
`ifdef BITWISE_GATES_XOR_EN
        .y_xor  (g_xor),
        .y_xnor (g_xnor),
`endif
        .y_and  (g_and),
        .y_nand (g_nand),
        .y_or   (g_or),
        .y_nor  (g_nor)
    );

    assign in_rdy  = (state == IDLE);
    assign out_val = (state == DONE);

    // FSM, counter, operand and result shift registers.
    // Results enter at the MSB so that after nbits shifts bit i lines up
    // with operand bit i.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            opa      <= '0;
            opb      <= '0;
            out_and  <= '0;
            out_nand <= '0;
            out_or   <= '0;
            out_nor  <= '0;
`ifdef BITWISE_GATES_XOR_EN
            out_xor  <= '0;
            out_xnor <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_val) begin
                        opa      <= in0;
                        opb      <= in1;
                        cnt      <= '0;
                        out_and  <= '0;
                        out_nand <= '0;
                        out_or   <= '0;
                        out_nor  <= '0;
`ifdef BITWISE_GATES_XOR_EN
                        out_xor  <= '0;
                        out_xnor <= '0;
`endif
                        state    <= CALC;
                    end
                end
                CALC: begin
                    out_and  <= {g_and,  out_and[nbits-1:1]};
                    out_nand <= {g_nand, out_nand[nbits-1:1]};
                    out_or   <= {g_or,   out_or[nbits-1:1]};
                    out_nor  <= {g_nor,  out_nor[nbits-1:1]};
`ifdef BITWISE_GATES_XOR_EN
                    out_xor  <= {g_xor,  out_xor[nbits-1:1]};
                    out_xnor <= {g_xnor, out_xnor[nbits-1:1]};
`endif
                    opa      <= opa >> 1;
                    opb      <= opb >> 1;
                    cnt      <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitwise_gates_serial.sv
module tb_bitwise_gates_serial;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_val, in_rdy, out_val, out_rdy;
    logic [3:0] in0, in1, out_and, out_nand, out_or, out_nor;
    logic       in_val8, in_rdy8, out_val8, out_rdy8;
    logic [7:0] in08, in18, out_and8, out_nand8, out_or8, out_nor8;
`ifdef BITWISE_GATES_XOR_EN
    logic [3:0] out_xor, out_xnor;
    logic [7:0] out_xor8, out_xnor8;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bitwise_gates_serial #(.nbits(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in0      (in0),
        .in1      (in1),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
`ifdef BITWISE_GATES_XOR_EN
        .out_xor  (out_xor),
        .out_xnor (out_xnor),
`endif
        .out_and  (out_and),
        .out_nand (out_nand),
        .out_or   (out_or),
        .out_nor  (out_nor)
    );

    bitwise_gates_serial #(.nbits(8)) dut8 (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_val   (in_val8),
        .in_rdy   (in_rdy8),
        .in0      (in08),
        .in1      (in18),
        .out_val  (out_val8),
        .out_rdy  (out_rdy8),
`ifdef BITWISE_GATES_XOR_EN
        .out_xor  (out_xor8),
        .out_xnor (out_xnor8),
`endif
        .out_and  (out_and8),
        .out_nand (out_nand8),
        .out_or   (out_or8),
        .out_nor  (out_nor8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        total++;
        if (in_rdy !== 1'b1) begin bad++; $display("FAIL reset_in_rdy got=%b want=1", in_rdy); end
        total++;
        if (out_val !== 1'b0) begin bad++; $display("FAIL reset_out_val got=%b want=0", out_val); end
        total++;
        if ({out_and, out_nand, out_or, out_nor} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_results got=%h want=0000", {out_and, out_nand, out_or, out_nor});
        end
`ifdef BITWISE_GATES_XOR_EN
        total++;
        if ({out_xor, out_xnor} !== 8'h00) begin bad++; $display("FAIL reset_xor got=%h want=00", {out_xor, out_xnor}); end
`endif
        total++;
        if (in_rdy8 !== 1'b1 || out_val8 !== 1'b0 || out_and8 !== 8'h00) begin
            bad++;
            $display("FAIL reset_dut8 got rdy=%b val=%b and=%h want rdy=1 val=0 and=00", in_rdy8, out_val8, out_and8);
        end
    endtask

    task automatic test_basic;
        out_rdy = 1'b1;
        in0 = 4'b1100; in1 = 4'b1010; in_val = 1'b1;
        tick();
        in_val = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++;
            if (out_val !== 1'b0) begin bad++; $display("FAIL basic_early_val cyc=%0d got=%b want=0", k, out_val); end
        end
        tick();
        total++;
        if (out_val !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b want=1", out_val); end
        total++;
        if ({out_and, out_nand, out_or, out_nor} !== {4'b1000, 4'b0111, 4'b1110, 4'b0001}) begin
            bad++;
            $display("FAIL basic_results got=%b_%b_%b_%b want=1000_0111_1110_0001", out_and, out_nand, out_or, out_nor);
        end
`ifdef BITWISE_GATES_XOR_EN
        total++;
        if ({out_xor, out_xnor} !== {4'b0110, 4'b1001}) begin
            bad++;
            $display("FAIL basic_xor got=%b_%b want=0110_1001", out_xor, out_xnor);
        end
`endif
        tick();
        total++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
            bad++;
            $display("FAIL basic_handoff got val=%b rdy=%b want val=0 rdy=1", out_val, in_rdy);
        end
        total++;
        if (out_and !== 4'b1000 || out_or !== 4'b1110) begin
            bad++;
            $display("FAIL basic_idle_hold got and=%b or=%b want and=1000 or=1110", out_and, out_or);
        end
    endtask

    task automatic test_backpressure;
        out_rdy = 1'b0;
        in0 = 4'hF; in1 = 4'h0; in_val = 1'b1;
        tick();
        in_val = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 6; k++) begin
            in_val = 1'b1; in0 = 4'h5; in1 = 4'h5;
            total++;
            if (out_val !== 1'b1 || in_rdy !== 1'b0 || out_and !== 4'b0000 || out_or !== 4'b1111) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got val=%b rdy=%b and=%b or=%b want val=1 rdy=0 and=0000 or=1111",
                         k, out_val, in_rdy, out_and, out_or);
            end
            tick();
        end
        in_val = 1'b0;
        out_rdy = 1'b1;
        tick();
        total++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1 || out_and !== 4'b0000 || out_or !== 4'b1111) begin
            bad++;
            $display("FAIL bp_release got val=%b rdy=%b and=%b or=%b want val=0 rdy=1 and=0000 or=1111",
                     out_val, in_rdy, out_and, out_or);
        end
    endtask

    task automatic test_back_to_back;
        out_rdy = 1'b1;
        in0 = 4'h3; in1 = 4'h5; in_val = 1'b1;
        tick();
        in0 = 4'h9; in1 = 4'h6;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t <= 3) begin
                total++;
                if (in_rdy !== 1'b0) begin bad++; $display("FAIL b2b_busy t=%0d got=%b want=0", t, in_rdy); end
            end
            if (t == 4) begin
                total++;
                if (out_val !== 1'b1 || out_and !== 4'b0001 || out_or !== 4'b0111) begin
                    bad++;
                    $display("FAIL b2b_first got val=%b and=%b or=%b want val=1 and=0001 or=0111", out_val, out_and, out_or);
                end
            end
            if (t == 5) begin
                total++;
                if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_idle got rdy=%b val=%b want rdy=1 val=0", in_rdy, out_val);
                end
            end
            if (t == 6) begin
                total++;
                if (in_rdy !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got rdy=%b want=0", in_rdy); end
            end
        end
        in_val = 1'b0;
        repeat (4) tick();
        total++;
        if (out_val !== 1'b1 || out_and !== 4'b0000 || out_or !== 4'b1111) begin
            bad++;
            $display("FAIL b2b_second got val=%b and=%b or=%b want val=1 and=0000 or=1111", out_val, out_and, out_or);
        end
        tick();
    endtask

    task automatic test_reset_mid_calc;
        out_rdy = 1'b1;
        in0 = 4'hC; in1 = 4'h3; in_val = 1'b1;
        tick();
        in_val = 1'b0;
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        total++;
        if (in_rdy !== 1'b1 || out_val !== 1'b0 || {out_and, out_nand, out_or, out_nor} !== 16'h0000) begin
            bad++;
            $display("FAIL midreset_async got rdy=%b val=%b res=%h want rdy=1 val=0 res=0000",
                     in_rdy, out_val, {out_and, out_nand, out_or, out_nor});
        end
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (out_val !== 1'b0) begin bad++; $display("FAIL midreset_no_val cyc=%0d got=%b want=0", k, out_val); end
        end
        in0 = 4'hA; in1 = 4'hA; in_val = 1'b1;
        tick();
        in_val = 1'b0;
        repeat (4) tick();
        total++;
        if (out_val !== 1'b1 || out_and !== 4'b1010 || out_nor !== 4'b0101) begin
            bad++;
            $display("FAIL midreset_next got val=%b and=%b nor=%b want val=1 and=1010 nor=0101", out_val, out_and, out_nor);
        end
        tick();
    endtask

    task automatic test_random4;
        logic [3:0] a, b;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a = 4'($urandom); b = 4'($urandom);
            total++;
            if (in_rdy !== 1'b1) begin bad++; $display("FAIL rnd4_ready i=%0d got=%b want=1", i, in_rdy); end
            in0 = a; in1 = b; in_val = 1'b1;
            tick();
            in_val = 1'b0;
            lat = -1;
            for (int c = 0; c < 20 && lat < 0; c++) begin
                if (out_val === 1'b1) lat = c;
                else begin out_rdy = 1'($urandom_range(0, 1)); tick(); end
            end
            total++;
            if (lat != 4) begin
                bad++;
                $display("FAIL rnd4_latency i=%0d got=%0d want=4", i, lat);
            end else if ({out_and, out_nand, out_or, out_nor} !== {a & b, ~(a & b), a | b, ~(a | b)}) begin
                bad++;
                $display("FAIL rnd4_result i=%0d a=%h b=%h got=%h want=%h", i, a, b,
                         {out_and, out_nand, out_or, out_nor}, {a & b, ~(a & b), a | b, ~(a | b)});
            end
`ifdef BITWISE_GATES_XOR_EN
            total++;
            if ({out_xor, out_xnor} !== {a ^ b, ~(a ^ b)}) begin
                bad++;
                $display("FAIL rnd4_xor i=%0d got=%h want=%h", i, {out_xor, out_xnor}, {a ^ b, ~(a ^ b)});
            end
`endif
            for (int c = 0; c < 40 && out_val === 1'b1; c++) begin
                out_rdy = (c >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
                tick();
            end
            out_rdy = 1'b0;
            total++;
            if (out_val !== 1'b0) begin bad++; $display("FAIL rnd4_drain i=%0d got=%b want=0", i, out_val); end
        end
    endtask

    task automatic test_random8;
        logic [7:0] a, b;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            total++;
            if (in_rdy8 !== 1'b1) begin bad++; $display("FAIL rnd8_ready i=%0d got=%b want=1", i, in_rdy8); end
            in08 = a; in18 = b; in_val8 = 1'b1;
            tick();
            in_val8 = 1'b0;
            lat = -1;
            for (int c = 0; c < 30 && lat < 0; c++) begin
                if (out_val8 === 1'b1) lat = c;
                else begin out_rdy8 = 1'($urandom_range(0, 1)); tick(); end
            end
            total++;
            if (lat != 8) begin
                bad++;
                $display("FAIL rnd8_latency i=%0d got=%0d want=8", i, lat);
            end else if ({out_and8, out_nand8, out_or8, out_nor8} !== {a & b, ~(a & b), a | b, ~(a | b)}) begin
                bad++;
                $display("FAIL rnd8_result i=%0d a=%h b=%h got=%h want=%h", i, a, b,
                         {out_and8, out_nand8, out_or8, out_nor8}, {a & b, ~(a & b), a | b, ~(a | b)});
            end
`ifdef BITWISE_GATES_XOR_EN
            total++;
            if ({out_xor8, out_xnor8} !== {a ^ b, ~(a ^ b)}) begin
                bad++;
                $display("FAIL rnd8_xor i=%0d got=%h want=%h", i, {out_xor8, out_xnor8}, {a ^ b, ~(a ^ b)});
            end
`endif
            for (int c = 0; c < 40 && out_val8 === 1'b1; c++) begin
                out_rdy8 = (c >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
                tick();
            end
            out_rdy8 = 1'b0;
            total++;
            if (out_val8 !== 1'b0) begin bad++; $display("FAIL rnd8_drain i=%0d got=%b want=0", i, out_val8); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        in_val  = 1'b0; in0 = '0; in1 = '0; out_rdy = 1'b0;
        in_val8 = 1'b0; in08 = '0; in18 = '0; out_rdy8 = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        test_random4();
        test_random8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
